// File: rtl/fetch_pc_unit.sv
// Fetch front end: holds the F-stage PC and the F/D pipeline register, and resolves the
// next fetch address from the D-stage control decision (jr, j, taken branch, or sequential).
module fetch_pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_MIN   = 32'h0000_3000,
    parameter logic [31:0] PC_MAX   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_f,
    input  logic        br_d,
    input  logic        br_likely_d,
    input  logic        cmp_out,
    input  logic        j_d,
    input  logic        jr_d,
    input  logic [31:0] rs_d,
    output logic [31:0] pc_f,
    output logic [31:0] npc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] link_d,
    output logic        adel_f
);

    logic [31:0] br_off;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] seq_pc;
    logic        br_taken;
    logic        nullify;

    // Offset is sign-extended to 32 bits first, then scaled to a byte offset.
    assign br_off    = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    assign br_target = pc_d + 32'd4 + br_off;
    assign j_target  = {pc_d[31:28], instr_d[25:0], 2'b00};
    assign seq_pc    = pc_f + 32'd4;
    assign br_taken  = br_d & cmp_out;
    assign nullify   = br_d & br_likely_d & ~cmp_out;

    always_comb begin
        npc = seq_pc;
        if (jr_d)
            npc = rs_d;
        else if (j_d)
            npc = j_target;
        else if (br_taken)
            npc = br_target;
    end

    assign link_d = pc_d + 32'd8;

    // Fetch is never blocked by a bad address; the flag travels with the instruction.
    assign adel_f = (pc_f[1:0] != 2'b00) | (pc_f < PC_MIN) | (pc_f > PC_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f    <= PC_RESET;
            instr_d <= 32'h0;
            pc_d    <= PC_RESET;
        end else if (!stall) begin
            pc_f    <= npc;
            pc_d    <= pc_f;
            // A not-taken likely branch squashes its delay slot into a nop.
            instr_d <= nullify ? 32'h0 : instr_f;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized control checked against
// an architectural model of PC sequencing with a sparse instruction memory.
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] instr_f;
    logic        br_d;
    logic        br_likely_d;
    logic        cmp_out;
    logic        j_d;
    logic        jr_d;
    logic [31:0] rs_d;
    logic [31:0] pc_f;
    logic [31:0] npc;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] link_d;
    logic        adel_f;

    int checks = 0;
    int errors = 0;

    logic [31:0] im [logic [31:0]];
    logic [31:0] m_pc_f;
    logic [31:0] m_pc_d;
    logic [31:0] m_instr_d;

    fetch_pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .instr_f(instr_f),
        .br_d(br_d), .br_likely_d(br_likely_d), .cmp_out(cmp_out),
        .j_d(j_d), .jr_d(jr_d), .rs_d(rs_d),
        .pc_f(pc_f), .npc(npc), .instr_d(instr_d), .pc_d(pc_d),
        .link_d(link_d), .adel_f(adel_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fetch(input logic [31:0] a);
        if (im.exists(a))
            return im[a];
        return {a[15:0] ^ 16'h5A3C, a[15:0] + 16'h1357};
    endfunction

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic bad;
        bad = (m_pc_f[1:0] != 2'b00) || (m_pc_f < 32'h3000) || (m_pc_f > 32'h6FFC);
        ck({tag, ".pc_f"}, pc_f, m_pc_f);
        ck({tag, ".pc_d"}, pc_d, m_pc_d);
        ck({tag, ".instr_d"}, instr_d, m_instr_d);
        ck({tag, ".link_d"}, link_d, m_pc_d + 32'd8);
        ck({tag, ".adel_f"}, {31'b0, adel_f}, {31'b0, bad});
    endtask

    // One cycle: drive at the falling edge, check mid-cycle, advance the model at the rising edge.
    task automatic step(input logic st, input logic br, input logic bl, input logic cmp,
                        input logic j, input logic jr, input logic [31:0] rs);
        logic [31:0] target;
        logic [31:0] offset;
        logic [31:0] fetched;
        fetched = fetch(m_pc_f);
        stall = st; br_d = br; br_likely_d = bl; cmp_out = cmp;
        j_d = j; jr_d = jr; rs_d = rs; instr_f = fetched;
        #1;
        offset = 32'(signed'(m_instr_d[15:0])) * 32'd4;
        if (jr)
            target = rs;
        else if (j)
            target = {m_pc_d[31:28], m_instr_d[25:0], 2'b00};
        else if (br && cmp)
            target = m_pc_d + 32'd4 + offset;
        else
            target = m_pc_f + 32'd4;
        check_state("step");
        if (!st)
            ck("step.npc", npc, target);
        @(posedge clk);
        if (!st) begin
            m_pc_d    = m_pc_f;
            m_instr_d = (br && bl && !cmp) ? 32'h0 : fetched;
            m_pc_f    = target;
        end
        @(negedge clk);
    endtask

    task automatic free(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_pc_f = 32'h3000; m_pc_d = 32'h3000; m_instr_d = 32'h0;
        ck("rst.pc_f", pc_f, 32'h0000_3000);
        ck("rst.pc_d", pc_d, 32'h0000_3000);
        ck("rst.instr_d", instr_d, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; instr_f = 32'h0; br_d = 1'b0; br_likely_d = 1'b0;
        cmp_out = 1'b0; j_d = 1'b0; jr_d = 1'b0; rs_d = 32'h0;
        @(negedge clk);

        // Free run after reset.
        do_reset();
        free(3);
        ck("seq.pc_f", pc_f, 32'h0000_300C);
        ck("seq.instr_d", instr_d, fetch(32'h3008));
        ck("seq.pc_d", pc_d, 32'h0000_3008);

        // beq forward, taken.
        im[32'h3010] = 32'h1000_0003;
        do_reset();
        free(5);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        ck("beq_fwd.pc_f", pc_f, 32'h0000_3020);
        ck("beq_fwd.pc_d", pc_d, 32'h0000_3014);
        ck("beq_fwd.slot", instr_d, fetch(32'h3014));

        // beq backward, taken and not taken.
        im[32'h3010] = 32'h1000_FFFF;
        do_reset();
        free(5);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        ck("beq_back.pc_f", pc_f, 32'h0000_3010);
        do_reset();
        free(5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        ck("beq_nt.pc_f", pc_f, 32'h0000_3018);

        // beql not taken squashes the delay slot.
        im[32'h3010] = 32'h5000_0003;
        do_reset();
        free(5);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        ck("beql.instr_d", instr_d, 32'h0);
        ck("beql.pc_d", pc_d, 32'h0000_3014);
        ck("beql.pc_f", pc_f, 32'h0000_3018);

        // jr under stall, then to an unaligned target.
        do_reset();
        free(9);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3402);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3402);
        ck("jr_hold.pc_f", pc_f, 32'h0000_3024);
        ck("jr_hold.pc_d", pc_d, 32'h0000_3020);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3402);
        ck("jr.pc_f", pc_f, 32'h0000_3402);
        ck("jr.adel_f", {31'b0, adel_f}, 32'h1);

        // j to its own address, then async reset in the middle of a stall.
        im[32'h3100] = 32'h0800_0C40;
        do_reset();
        free(9);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3100);
        free(1);
        ck("j.pc_d", pc_d, 32'h0000_3100);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        ck("j.pc_f", pc_f, 32'h0000_3100);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        do_reset();
        free(1);

        // Randomized one-hot control traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int          r;
            logic        st;
            logic [31:0] rs;
            r  = $urandom_range(0, 9);
            st = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 1) == 1) ? (32'h3000 + ($urandom_range(0, 4095) << 2)) : $urandom;
            case (r)
                0, 1: step(st, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'b0, 1'b0, rs);
                2:    step(st, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, rs);
                3:    step(st, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, rs);
                default: step(st, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, rs);
            endcase
            if ($urandom_range(0, 99) == 0)
                do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
